sfifo_ctrl: RTL

Single-clock synchronous FIFO, the next generation of the team's FIFO family. It uses the same parameter set and status vocabulary as the async FIFO wrapper, and adds:
- a first-word-fall-through (FWFT) mode
- a read latency selectable per instance
- a sticky error capture that records which side erred first, with software clear

It is used for intra-clock-domain buffering in the AXI width converters, where a CDC FIFO is wasted area.

---
 rtl/sfifo_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sfifo_ctrl.sv
// sfifo_ctrl: single-clock FIFO with standard/FWFT read, selectable read latency and sticky error capture
module sfifo_ctrl #(
  parameter int U_DLY             = 1,
  parameter int FIFO_WIDTHBIT     = 32,
  parameter int FIFO_DEPTHBIT     = 4,
  parameter int FIFO_NAFULL_SIZE  = 4,
  parameter int FIFO_NAEMPTY_SIZE = 4,
  parameter int FIFO_READ_DELAY   = 1,
  parameter int FIFO_FWFT         = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_wen,
  input  logic [FIFO_WIDTHBIT-1:0] fifo_wdata,
  output logic                     fifo_nfull,
  output logic                     fifo_nafull,
  input  logic                     fifo_ren,
  output logic [FIFO_WIDTHBIT-1:0] fifo_rdata,
  output logic                     fifo_rvld,
  output logic                     fifo_nempty,
  output logic                     fifo_naempty,
  output logic [FIFO_DEPTHBIT:0]   fifo_cnt,
  input  logic                     fifo_clr_err,
  output logic                     fifo_overflow,
  output logic                     fifo_underflow,
  output logic                     fifo_err_side
);
  localparam int DB = FIFO_DEPTHBIT;
  localparam int W = FIFO_WIDTHBIT;
  localparam int DEPTH = 1 << DB;
  localparam logic [DB:0] CNT_FULL = (DB+1)'(DEPTH);
  localparam bit FWFT = FIFO_FWFT != 0;
  localparam bit RL2 = FIFO_READ_DELAY == 2;

  if (FIFO_DEPTHBIT < 2 || FIFO_DEPTHBIT > 12 || FIFO_NAFULL_SIZE < 1 || FIFO_NAFULL_SIZE > DEPTH - 1 ||
      FIFO_NAEMPTY_SIZE < 1 || FIFO_NAEMPTY_SIZE > DEPTH - 1 || (FIFO_READ_DELAY != 1 && FIFO_READ_DELAY != 2) ||
      FIFO_FWFT < 0 || FIFO_FWFT > 1 || U_DLY < 0) begin : g_bad_param
    $error("sfifo_ctrl: illegal parameter value");
  end

  logic [W-1:0]  r_mem [0:DEPTH-1];
  logic [DB-1:0] r_wptr, r_rptr;
  logic [DB:0]   r_cnt;
  logic [W-1:0]  r_q1, r_q2;
  logic          r_v1, r_v2;
  logic [W-1:0]  r_pq [0:2];
  logic [W-1:0]  w_pq [0:2];
  logic [1:0]    r_pn, r_pf, w_pf_net, w_pq_idx;
  logic          r_ovf, r_unf, r_side;
  logic [W-1:0]  w_arr_d;
  logic          w_arr_v, w_rvld, w_pop, w_rd_acc, w_issue, w_wr_acc;
  logic          w_ovf, w_unf, w_shift, w_push, w_ovf_b, w_unf_b, w_side_b, w_first;

  // In FWFT mode the RAM is read ahead whenever a word is stored and a prefetch slot is free
  assign w_arr_v  = RL2 ? r_v2 : r_v1;
  assign w_arr_d  = RL2 ? r_q2 : r_q1;
  assign w_rvld   = FWFT ? (r_pn != 2'd0 || w_arr_v) : w_arr_v;
  assign w_pop    = fifo_ren && w_rvld;
  assign w_rd_acc = FWFT ? w_pop : (fifo_ren && r_cnt != '0);
  assign w_pf_net = r_pf - {1'b0, w_pop};
  assign w_issue  = FWFT ? (r_cnt > (DB+1)'(r_pf) && w_pf_net < 2'(FIFO_READ_DELAY + 1)) : w_rd_acc;
  assign w_wr_acc = fifo_wen && (r_cnt != CNT_FULL || w_rd_acc);
  assign w_ovf    = fifo_wen && !w_wr_acc;
  assign w_unf    = fifo_ren && !w_rd_acc;
  assign w_shift  = w_pop && r_pn != 2'd0;
  assign w_push   = w_arr_v && !(w_pop && r_pn == 2'd0);
  assign w_pq_idx = r_pn - {1'b0, w_shift};
  assign w_ovf_b  = r_ovf && !fifo_clr_err;
  assign w_unf_b  = r_unf && !fifo_clr_err;
  assign w_side_b = r_side && !fifo_clr_err;
  assign w_first  = !(w_ovf_b || w_unf_b) && (w_ovf || w_unf);

  // Next prefetch queue: drop the popped head, append the word arriving from the RAM pipeline
  always_comb begin
    w_pq[0] = w_shift ? r_pq[1] : r_pq[0];
    w_pq[1] = w_shift ? r_pq[2] : r_pq[1];
    w_pq[2] = r_pq[2];
    if (w_push) w_pq[w_pq_idx] = w_arr_d;
  end

  // Storage array write port
  always_ff @(posedge clk)
    if (w_wr_acc) r_mem[r_wptr] <= fifo_wdata;

  // Pointers, total occupancy and outstanding prefetch count
  always_ff @(posedge clk)
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_pf   <= '0;
    end else begin
      r_wptr <= r_wptr + DB'(w_wr_acc);
      r_rptr <= r_rptr + DB'(w_issue);
      r_cnt  <= r_cnt + (DB+1)'(w_wr_acc) - (DB+1)'(w_rd_acc);
      r_pf   <= FWFT ? r_pf + 2'(w_issue) - 2'(w_pop) : 2'd0;
    end

  // Registered RAM read plus optional second output stage; data holds between reads
  always_ff @(posedge clk)
    if (rst) begin
      r_q1 <= '0;
      r_q2 <= '0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= w_issue;
      r_v2 <= r_v1;
      if (w_issue) r_q1 <= r_mem[r_rptr];
      if (r_v1) r_q2 <= r_q1;
    end

  // FWFT holding queue for words that arrived but have not been popped
  always_ff @(posedge clk)
    if (rst) begin
      r_pn <= 2'd0;
      r_pq <= '{default: '0};
    end else if (FWFT) begin
      r_pn <= r_pn - {1'b0, w_shift} + {1'b0, w_push};
      r_pq <= w_pq;
    end

  // Sticky error flags; a new error beats a same-cycle clear and re-latches the side
  always_ff @(posedge clk)
    if (rst) begin
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_side <= 1'b0;
    end else begin
      r_ovf  <= w_ovf_b || w_ovf;
      r_unf  <= w_unf_b || w_unf;
      r_side <= w_first ? w_unf : w_side_b;
    end

  assign fifo_rdata     = (FWFT && r_pn != 2'd0) ? r_pq[0] : w_arr_d;
  assign fifo_rvld      = w_rvld;
  assign fifo_cnt       = r_cnt;
  assign fifo_nfull     = r_cnt != CNT_FULL;
  assign fifo_nafull    = (CNT_FULL - r_cnt) > (DB+1)'(FIFO_NAFULL_SIZE);
  assign fifo_nempty    = r_cnt != '0;
  assign fifo_naempty   = r_cnt > (DB+1)'(FIFO_NAEMPTY_SIZE);
  assign fifo_overflow  = r_ovf;
  assign fifo_underflow = r_unf;
  assign fifo_err_side  = r_side;
endmodule
